// File: rtl/imm_ext_pkg.sv
// Shared types for the immediate-extension pipeline: extension modes and
// the skid-buffer occupancy states.
package imm_ext_pkg;

  // Extension mode carried alongside each immediate
  typedef enum logic [1:0] {
    IMM_ZERO  = 2'b00,
    IMM_SIGN  = 2'b01,
    IMM_SHL2  = 2'b10,
    IMM_UPPER = 2'b11
  } imm_mode_e;

  // Number of results currently held by the skid buffer
  typedef enum logic [1:0] {
    SK_EMPTY = 2'b00,
    SK_ONE   = 2'b01,
    SK_TWO   = 2'b10
  } skid_state_e;

  // Branch offsets are word offsets, so SHL2 scales by four
  localparam int SHL_AMT = 2;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero/sign extension, sign-extend and
// scale by four (with truncation detection), and upper placement.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  imm_mode_e        mode,
  output logic [OUT_W-1:0] data,
  output logic             trunc
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0]         zeroExt;
  logic [OUT_W-1:0]         signExt;
  logic [OUT_W-1:0]         upperExt;
  logic [OUT_W+SHL_AMT-1:0] shlWide;

  // Build every extended form bit by bit so that PAD==0 needs no
  // zero-width replication.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : gBit
      if (gi < IN_W) begin : gLow
        assign zeroExt[gi] = imm[gi];
        assign signExt[gi] = imm[gi];
      end else begin : gHigh
        assign zeroExt[gi] = 1'b0;
        assign signExt[gi] = imm[IN_W-1];
      end
      if (gi >= PAD) begin : gUp
        assign upperExt[gi] = imm[gi-PAD];
      end else begin : gUpZero
        assign upperExt[gi] = 1'b0;
      end
    end
  endgenerate

  // Full-precision shifted value; the top two bits are the ones dropped
  assign shlWide = {signExt, {SHL_AMT{1'b0}}};

  // Select the result for the requested mode; only SHL2 can lose bits
  always_comb begin
    data  = '0;
    trunc = 1'b0;
    case (mode)
      IMM_ZERO:  data = zeroExt;
      IMM_SIGN:  data = signExt;
      IMM_SHL2: begin
        data  = shlWide[OUT_W-1:0];
        trunc = (shlWide[OUT_W+1] != shlWide[OUT_W-1]) ||
                (shlWide[OUT_W]   != shlWide[OUT_W-1]);
      end
      IMM_UPPER: data = upperExt;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender for decode: extends on acceptance and
// holds up to two results in a skid buffer behind a valid/ready handshake.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  imm_mode_e        in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_trunc
);

  // Each entry stores {trunc, data}
  localparam int ENT_W = OUT_W + 1;

  generate
    if (IN_W < 1 || IN_W > OUT_W) begin : gBadWidth
      $error("imm_ext_pipe: IN_W must be in 1..OUT_W");
    end
  endgenerate

  skid_state_e      stateReg;
  logic [ENT_W-1:0] headReg;
  logic [ENT_W-1:0] tailReg;
  logic             inReadyReg;
  logic             outValidReg;

  logic [OUT_W-1:0] extData;
  logic             extTrunc;
  logic [ENT_W-1:0] extEntry;
  logic             pushing;
  logic             popping;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) uCore (
    .imm   (in_imm),
    .mode  (in_mode),
    .data  (extData),
    .trunc (extTrunc)
  );

  assign extEntry = {extTrunc, extData};
  assign pushing  = in_valid && inReadyReg;
  assign popping  = outValidReg && out_ready;

  // Skid FSM: occupancy state, entry registers and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= SK_EMPTY;
      headReg     <= '0;
      tailReg     <= '0;
      inReadyReg  <= 1'b1;
      outValidReg <= 1'b0;
    end else begin
      case (stateReg)
        SK_EMPTY: begin
          if (pushing) begin
            headReg     <= extEntry;
            outValidReg <= 1'b1;
            stateReg    <= SK_ONE;
          end
        end
        SK_ONE: begin
          if (pushing && popping) begin
            headReg <= extEntry;
          end else if (pushing) begin
            tailReg    <= extEntry;
            inReadyReg <= 1'b0;
            stateReg   <= SK_TWO;
          end else if (popping) begin
            outValidReg <= 1'b0;
            stateReg    <= SK_EMPTY;
          end
        end
        SK_TWO: begin
          if (popping) begin
            headReg    <= tailReg;
            inReadyReg <= 1'b1;
            stateReg   <= SK_ONE;
          end
        end
        default: begin
          outValidReg <= 1'b0;
          inReadyReg  <= 1'b1;
          stateReg    <= SK_EMPTY;
        end
      endcase
    end
  end

  assign in_ready  = inReadyReg;
  assign out_valid = outValidReg;
  assign out_data  = headReg[OUT_W-1:0];
  assign out_trunc = headReg[OUT_W];

endmodule

// File: doc/imm_ext_pipe.md
# imm_ext_pipe

Parametrised, registered immediate-extension unit for the decode stage. It takes an IN_W-bit instruction immediate plus a mode and produces an OUT_W-bit operand. Modes are zero-extend, sign-extend, sign-extend-and-shift-left-2 for branch offsets, and upper placement for LUI. Results pass through a 2-entry skid buffer with a valid/ready handshake, so decode can stall without losing or reordering immediates. It replaces the fixed-width combinational extenders (5, 8 and 16 to 32 bits, and 16 to 30 bits).

## Interface
Parameters:
- IN_W, default 16: immediate input width; legal values are 1 to OUT_W.
- OUT_W, default 32: extended output width.

Ports:
- clk  in  1  rising-edge clock; the block uses this single clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream offers an immediate.
- in_ready  out  1  block can accept; driven directly from a register.
- in_imm  in  IN_W  raw immediate field.
- in_mode  in  2  extension mode, one of the imm_mode_e values.
- out_valid  out  1  output holds a result.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_W  extended immediate.
- out_trunc  out  1  set when the result lost significant bits; only SHL2 can set it.

## Operation
Mode rules, where E is IN_W-bit x extended to OUT_W bits:
- ZERO (2'b00): {0…, x}.
- SIGN (2'b01): {x[IN_W-1] replicated, x}.
- SHL2 (2'b10): the sign-extended value shifted left by 2, truncated to OUT_W.
  - out_trunc=1 when the two bits dropped from the OUT_W+2-bit intermediate are not both equal to the result's MSB.
- UPPER (2'b11): x << (OUT_W-IN_W), low bits zero.
  - When IN_W==OUT_W this equals ZERO.
- out_trunc=0 in every mode except SHL2.

Handshake:
- A transfer occurs on a rising edge where valid && ready.
- Extension is computed on input acceptance, and the computed result is what gets stored.

Skid buffer states:
- EMPTY:
  - in_ready=1, out_valid=0.
  - Accept: go to ONE.
- ONE:
  - in_ready=1, out_valid=1.
  - Accept only: go to TWO.
  - Output transfer only: go to EMPTY.
  - Accept and output transfer together: stay in ONE; the head is replaced by the new entry.
- TWO:
  - in_ready=0, out_valid=1.
  - Output transfer: go to ONE; the second entry moves to the head.
  - in_valid is ignored.

Ordering and stability:
- Strict FIFO order is preserved.
- out_data and out_trunc stay stable while out_valid=1 and out_ready=0.
- in_mode and in_imm are sampled only when an input transfer occurs.

## Timing
Reset values (rst_n low, asynchronous):
- State EMPTY.
- out_valid=0, in_ready=1.
- out_data=0, out_trunc=0, both buffer entries cleared.

Reset behaviour:
- Reset takes effect immediately; it does not wait for a clock edge.
- Any held entries are discarded.
- After rst_n deasserts, the first edge with in_valid=1 is accepted.

Latency:
- 1 cycle: an input accepted at edge N is visible on out_data after edge N, when starting from EMPTY.
- Throughput is 1 per cycle while out_ready=1.

Backpressure:
- in_ready falls the cycle after the second entry is captured while out_ready=0.
- in_ready rises the cycle after the output transfer out of TWO.

Other rules:
- No combinational path from out_ready to in_ready.
- in_valid while in_ready=0 has no effect; the upstream stage must hold its data.

## Structure
- Shared package imm_ext_pkg:
  - typedef enum logic [1:0] imm_mode_e {IMM_ZERO, IMM_SIGN, IMM_SHL2, IMM_UPPER}.
  - The skid state enum {SK_EMPTY, SK_ONE, SK_TWO}.
- Sub-module imm_ext_core: purely combinational, parametrised IN_W/OUT_W; computes data and trunc from imm and mode.
- Top level: skid FSM plus two entry registers of OUT_W+1 bits each.
- Elaboration-time check: IN_W ≤ OUT_W.

## Test plan
- Mode values, with IN_W=16, OUT_W=32, in_imm=16'h8001 and out_ready=1:
  - ZERO → 32'h00008001.
  - SIGN → 32'hFFFF8001.
  - SHL2 → 32'hFFFE0004, trunc=0.
  - UPPER → 32'h80010000.
  - Each result appears 1 cycle after acceptance.
- Legacy widths:
  - IN_W=5, OUT_W=32, SIGN, 5'b10000 → 32'hFFFFFFF0.
  - IN_W=8, ZERO, 8'hFF → 32'h000000FF.
- Truncation, with IN_W=16, OUT_W=16, SHL2:
  - 16'h4000 → out_data=16'h0000, out_trunc=1.
  - 16'hFFFF → 16'hFFFC, out_trunc=0.
- Backpressure:
  - Setup: out_ready=0; offer A=1, B=2, C=3 in SIGN mode on consecutive cycles.
  - A and B are accepted; in_ready=0 and C is held.
  - Raise out_ready: the outputs are 1, 2, 3 in order, with no duplicates or drops.
- Simultaneous push and pop in ONE:
  - out_data updates to the new entry each cycle.
  - in_ready stays 1 and out_valid stays 1.
- Reset mid-operation:
  - Setup: state TWO; assert rst_n=0 between clock edges.
  - out_valid=0, in_ready=1 and out_data=0 immediately.
  - The held entries never appear on the output after release.
